fft_frame_sequencer: RTL and testbench

//  Sequences the FFT datapath per audio frame: accepts the codec "buffer full" pulse, decimates

---
 rtl/fft_frame_sequencer_pkg.sv | 15 +
 rtl/fft_frame_sequencer_if.sv | 24 ++
 rtl/fft_frame_sequencer_sat_counter.sv | 30 +++
 rtl/fft_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_fft_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types for the FFT frame sequencer.
// State encoding is also read by status/LED decoders.
package fft_frame_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_START   = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_PUBLISH = 3'd3,
    SEQ_FAULT   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// FFT start/done and display req/ack handshakes.
// master = sequencer, slave = FFT block + readout.
interface fft_frame_sequencer_if;

  logic fft_start_o;
  logic fft_done_i;
  logic disp_req_o;
  logic disp_ack_i;

  modport master (
    output fft_start_o,
    output disp_req_o,
    input  fft_done_i,
    input  disp_ack_i
  );

  modport slave (
    input  fft_start_o,
    input  disp_req_o,
    output fft_done_i,
    output disp_ack_i
  );

endinterface

// File: rtl/fft_frame_sequencer_sat_counter.sv
// Saturating up-counter with clear taking
// priority over increment.
module fft_frame_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)
      q_d = '0;
    else if (inc_i && (q_q != '1))
      q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Per-frame FFT sequencer: decimation, start,
// watchdog, readout handshake, frame stats.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int FRAME_DECIM    = 1,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic                buff_ready_i,
  fft_frame_sequencer_if.master bus,
  output logic [CNT_W-1:0]    frame_cnt_o,
  output logic [CNT_W-1:0]    overrun_cnt_o,
  output logic                timeout_o,
  output logic [STATE_W-1:0]  state_o
);

  localparam int SKIP_W = $clog2(FRAME_DECIM) + 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [SKIP_W-1:0] SKIP_RLD =
    SKIP_W'(FRAME_DECIM - 1);
  localparam logic [WD_W-1:0] WD_RLD =
    WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic              rdy_go;
  logic              frame_inc;
  logic              ovr_inc;

  assign rdy_go = buff_ready_i & enable_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      skip_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      SEQ_IDLE: begin
        if (rdy_go) begin
          if (skip_q == '0) begin
            state_d = SEQ_START;
            skip_d  = SKIP_RLD;
          end else begin
            skip_d  = skip_q - SKIP_W'(1);
          end
        end
      end
      SEQ_START: begin
        wd_d    = WD_RLD;
        state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        // done on the last watchdog cycle still publishes
        if (bus.fft_done_i) begin
          state_d = SEQ_PUBLISH;
        end else if (wd_q == '0) begin
          state_d   = SEQ_FAULT;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      SEQ_PUBLISH: begin
        if (bus.disp_ack_i) state_d = SEQ_IDLE;
      end
      SEQ_FAULT: begin
        if (!enable_i) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (clear_i) timeout_d = 1'b0;
  end

  always_comb begin
    bus.fft_start_o = (state_q == SEQ_START);
    bus.disp_req_o  = (state_q == SEQ_PUBLISH);
    frame_inc = (state_q == SEQ_PUBLISH)
              & bus.disp_ack_i;
    ovr_inc   = rdy_go & (state_q != SEQ_IDLE);
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

  fft_frame_sequencer_sat_counter #(
    .W (CNT_W)
  ) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (frame_inc),
    .clr_i (clear_i),
    .q_o   (frame_cnt_o)
  );

  fft_frame_sequencer_sat_counter #(
    .W (CNT_W)
  ) u_overrun_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ovr_inc),
    .clr_i (clear_i),
    .q_o   (overrun_cnt_o)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench: u0 (DECIM=1, TIMEOUT=16, CNT_W=4),
// u1 (DECIM=4, TIMEOUT=256); start scoreboard.
module tb_fft_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic en0 = 1'b1, clr0 = 1'b0, rdy0 = 1'b0;
  logic en1 = 1'b1, clr1 = 1'b0, rdy1 = 1'b0;
  logic [3:0]  fc0, oc0;
  logic [15:0] fc1, oc1;
  logic        to0, to1;
  logic [2:0]  st0, st1;

  int cyc = 0;
  int vec = 0;
  int err = 0;
  int sq0[$];
  int sq1[$];

  fft_frame_sequencer_if bus0();
  fft_frame_sequencer_if bus1();

  fft_frame_sequencer #(
    .FRAME_DECIM    (1),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (4)
  ) u0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (en0),
    .clear_i       (clr0),
    .buff_ready_i  (rdy0),
    .bus           (bus0),
    .frame_cnt_o   (fc0),
    .overrun_cnt_o (oc0),
    .timeout_o     (to0),
    .state_o       (st0)
  );

  fft_frame_sequencer #(
    .FRAME_DECIM    (4),
    .TIMEOUT_CYCLES (256),
    .CNT_W          (16)
  ) u1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (en1),
    .clear_i       (clr1),
    .buff_ready_i  (rdy1),
    .bus           (bus1),
    .frame_cnt_o   (fc1),
    .overrun_cnt_o (oc1),
    .timeout_o     (to1),
    .state_o       (st1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // each start pulse must match a queued cycle
  always @(negedge clk) begin
    if (bus0.fft_start_o === 1'b1) begin
      if (sq0.size() == 0)
        chk("u0_start_extra", 1, 0);
      else
        chk("u0_start_cyc", cyc, sq0.pop_front());
    end
    if (bus1.fft_start_o === 1'b1) begin
      if (sq1.size() == 0)
        chk("u1_start_extra", 1, 0);
      else
        chk("u1_start_cyc", cyc, sq1.pop_front());
    end
  end

  task automatic go0();
    sq0.push_back(cyc + 1);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    tick(1);
  endtask

  task automatic done0(int k);
    tick(k - 1);
    bus0.fft_done_i = 1'b1;
    tick(1);
    bus0.fft_done_i = 1'b0;
  endtask

  task automatic ack0();
    bus0.disp_ack_i = 1'b1;
    tick(1);
    bus0.disp_ack_i = 1'b0;
  endtask

  initial begin
    bus0.fft_done_i = 1'b0;
    bus0.disp_ack_i = 1'b0;
    bus1.fft_done_i = 1'b0;
    bus1.disp_ack_i = 1'b0;
    tick(3);
    chk("rst_st0", st0, 0);
    chk("rst_start0", bus0.fft_start_o, 0);
    chk("rst_req0", bus0.disp_req_o, 0);
    chk("rst_fc0", fc0, 0);
    chk("rst_oc0", oc0, 0);
    chk("rst_to0", to0, 0);
    chk("rst_st1", st1, 0);
    chk("rst_fc1", fc1, 0);
    rst_n = 1'b1;
    tick(2);

    go0();
    done0(10);
    chk("basic_req", bus0.disp_req_o, 1);
    chk("basic_st", st0, 3);
    ack0();
    chk("basic_idle", st0, 0);
    chk("basic_req_off", bus0.disp_req_o, 0);
    chk("basic_fc", fc0, 1);

    go0();
    done0(16);
    chk("lastrun_pub", st0, 3);
    ack0();
    chk("lastrun_fc", fc0, 2);

    go0();
    tick(2);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    done0(1);
    bus0.disp_ack_i = 1'b1;
    rdy0 = 1'b1;
    tick(1);
    bus0.disp_ack_i = 1'b0;
    rdy0 = 1'b0;
    tick(3);
    chk("ovr_oc", oc0, 2);
    chk("ovr_fc", fc0, 3);
    chk("ovr_st", st0, 0);

    go0();
    done0(2);
    clr0 = 1'b1;
    bus0.disp_ack_i = 1'b1;
    tick(1);
    clr0 = 1'b0;
    bus0.disp_ack_i = 1'b0;
    chk("clrack_fc", fc0, 0);
    chk("clrack_oc", oc0, 0);
    chk("clrack_st", st0, 0);

    go0();
    tick(15);
    chk("wd_run16", st0, 2);
    tick(1);
    chk("wd_fault", st0, 4);
    chk("wd_to", to0, 1);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    chk("fault_ovr", oc0, 1);
    tick(3);
    chk("fault_hold", st0, 4);
    en0 = 1'b0;
    tick(1);
    chk("fault_exit", st0, 0);
    chk("to_sticky", to0, 1);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    tick(2);
    chk("dis_rdy_oc", oc0, 1);
    chk("dis_rdy_st", st0, 0);
    en0 = 1'b1;
    bus0.fft_done_i = 1'b1;
    tick(1);
    bus0.fft_done_i = 1'b0;
    chk("idle_done_st", st0, 0);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    chk("clr_to", to0, 0);
    chk("clr_oc", oc0, 0);

    for (int i = 0; i < 20; i++) begin
      go0();
      done0(1);
      ack0();
    end
    chk("sat_fc", fc0, 15);

    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) sq1.push_back(cyc + 1);
      rdy1 = 1'b1;
      tick(1);
      rdy1 = 1'b0;
      if (i % 4 == 0) begin
        tick(100);
        chk("dec_run", st1, 2);
        bus1.fft_done_i = 1'b1;
        tick(1);
        bus1.fft_done_i = 1'b0;
        chk("dec_req", bus1.disp_req_o, 1);
        bus1.disp_ack_i = 1'b1;
        tick(1);
        bus1.disp_ack_i = 1'b0;
      end
      tick(20);
    end
    chk("dec_fc", fc1, 2);
    chk("dec_oc", oc1, 0);
    chk("dec_st", st1, 0);

    go0();
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_st", st0, 0);
    chk("arst_start", bus0.fft_start_o, 0);
    chk("arst_req", bus0.disp_req_o, 0);
    chk("arst_fc", fc0, 0);
    chk("arst_to", to0, 0);
    chk("arst_fc1", fc1, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    go0();
    done0(5);
    ack0();
    chk("post_rst_fc", fc0, 1);

    tick(5);
    chk("u0_sq_left", sq0.size(), 0);
    chk("u1_sq_left", sq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule
